// File: rtl/burst_ram_arbiter.sv
// Purpose: shares one BurstRAM command/data port between the icache (port I) and dcache (port D), round-robin.
// Latency: 1 clock from request (idle, br_busy low) to br_cmd_en; the owner keeps the port until its burst completes.
// Backpressure: br_busy holds requests in IDLE; requesters hold req until their gnt pulse, and nothing is queued.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   i_*/d_* inputs         per-requester req, cmd (0 rd / 1 wr), addr, write beat and byte mask
//   i_gnt/d_gnt            one-cycle pulse when the requester's command is on the RAM port
//   i_rd_valid/d_rd_valid  read beat strobe for the owning requester; rd_data is shared
//   i_busy/d_busy          arbiter not idle, or the requester's own request pending
//   br_*                   BurstRAM command, address, write data/mask, read data/valid, busy
//   timeout                one-cycle pulse when a read burst is abandoned
// Optional: define ARB_TIMEOUT_EN to enable the read-burst watchdog (TIMEOUT_CYCLES); otherwise timeout is 0.
module burst_ram_arbiter #(
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT    = 4,
  parameter int TIMEOUT_CYCLES          = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_req,
  input  logic                                 d_req,
  input  logic                                 i_cmd,
  input  logic                                 d_cmd,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        i_addr,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        d_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   i_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   d_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] i_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] d_data_mask,
  output logic                                 i_gnt,
  output logic                                 d_gnt,
  output logic                                 i_rd_valid,
  output logic                                 d_rd_valid,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   rd_data,
  output logic                                 i_busy,
  output logic                                 d_busy,
  output logic                                 br_cmd,
  output logic                                 br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                                 br_rd_data_valid,
  input  logic                                 br_busy,
  output logic                                 timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam int            CW        = $clog2(RAM_BURST_DATA_COUNT);
  localparam logic [CW-1:0] LAST_BEAT = CW'(RAM_BURST_DATA_COUNT - 1);

  // Owner encoding: 0 = I, 1 = D.
  logic [1:0]                    state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          owner_q, owner_d;
  logic                          last_owner_q, last_owner_d;
  logic                          cmd_q, cmd_d;
  logic [RAM_DEPTH_BITWIDTH-1:0] addr_q, addr_d;
  logic                          cmd_en_q, cmd_en_d;
  logic                          i_gnt_q, i_gnt_d;
  logic                          d_gnt_q, d_gnt_d;
  logic                          winner;

`ifdef ARB_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;
`endif

  // Sole requester wins; on a tie the one that did not own the port last time.
  assign winner = (i_req && d_req) ? ~last_owner_q : d_req;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    cmd_en_d     = 1'b0;
    i_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_d        = tmo_q;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if ((i_req || d_req) && !br_busy) begin
          state_d      = S_ISSUE;
          owner_d      = winner;
          last_owner_d = winner;
          cmd_d        = winner ? d_cmd : i_cmd;
          addr_d       = winner ? d_addr : i_addr;
          cmd_en_d     = 1'b1;
          i_gnt_d      = ~winner;
          d_gnt_d      = winner;
        end
      end
      S_ISSUE: begin
        // A write's first beat rides along with the command, so the count starts at 1.
        if (cmd_q) begin
          state_d = S_WRITE;
          cnt_d   = CW'(1);
        end else begin
          state_d = S_READ;
          cnt_d   = '0;
        end
`ifdef ARB_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      S_WRITE: begin
        if (cnt_q == LAST_BEAT) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin // S_READ
        if (br_rd_data_valid) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef ARB_TIMEOUT_EN
        // Watchdog measures the gap since the last beat (or since issue).
        if (br_rd_data_valid) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          tmo_d     = '0;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cmd_q        <= 1'b0;
      addr_q       <= '0;
      cmd_en_q     <= 1'b0;
      i_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      cmd_en_q     <= cmd_en_d;
      i_gnt_q      <= i_gnt_d;
      d_gnt_q      <= d_gnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign br_cmd    = cmd_q;
  assign br_cmd_en = cmd_en_q;
  assign br_addr   = addr_q;
  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign rd_data   = br_rd_data;

  // Beats arriving outside READ (stale bursts after reset or timeout) are dropped here.
  assign i_rd_valid = (state_q == S_READ) && !owner_q && br_rd_data_valid;
  assign d_rd_valid = (state_q == S_READ) &&  owner_q && br_rd_data_valid;

  assign i_busy = (state_q != S_IDLE) || i_req;
  assign d_busy = (state_q != S_IDLE) || d_req;

  always_comb begin
    br_wr_data   = '0;
    br_data_mask = '0;
    if (state_q == S_ISSUE || state_q == S_WRITE) begin
      br_wr_data   = owner_q ? d_wr_data   : i_wr_data;
      br_data_mask = owner_q ? d_data_mask : i_data_mask;
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Purpose: directed bench for burst_ram_arbiter with queued expectations and a negedge monitor.
// Latency: expects br_cmd_en/gnt one clock after a request is seen in IDLE.
// Backpressure: exercises br_busy stall, held requests while busy, and reset mid-burst.
module tb_burst_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 64;
  localparam int BC = 4;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, i_cmd, d_cmd;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wr_data, d_wr_data;
  logic [MW-1:0] i_data_mask, d_data_mask;
  logic          i_gnt, d_gnt, i_rd_valid, d_rd_valid;
  logic [DW-1:0] rd_data;
  logic          i_busy, d_busy;
  logic          br_cmd, br_cmd_en;
  logic [AW-1:0] br_addr;
  logic [DW-1:0] br_wr_data;
  logic [MW-1:0] br_data_mask;
  logic [DW-1:0] br_rd_data;
  logic          br_rd_data_valid, br_busy;
  logic          timeout;

  burst_ram_arbiter #(
    .RAM_DEPTH_BITWIDTH(AW), .RAM_BURST_DATA_BITWIDTH(DW),
    .RAM_BURST_DATA_COUNT(BC), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .d_req(d_req), .i_cmd(i_cmd), .d_cmd(d_cmd),
    .i_addr(i_addr), .d_addr(d_addr),
    .i_wr_data(i_wr_data), .d_wr_data(d_wr_data),
    .i_data_mask(i_data_mask), .d_data_mask(d_data_mask),
    .i_gnt(i_gnt), .d_gnt(d_gnt),
    .i_rd_valid(i_rd_valid), .d_rd_valid(d_rd_valid), .rd_data(rd_data),
    .i_busy(i_busy), .d_busy(d_busy),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
    .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
    .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
    .br_busy(br_busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ig;
    logic          dg;
    logic          cmd;
    logic [AW-1:0] addr;
  } cmd_exp_t;

  typedef struct packed {
    logic [1:0]    vld; // {i_rd_valid, d_rd_valid}
    logic [DW-1:0] dat;
  } rd_exp_t;

  cmd_exp_t      cmd_q[$];
  rd_exp_t       rd_q[$];
  logic [DW-1:0] wd_q[$];
  logic [MW-1:0] wm_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen with no expectation pending", name);
  endtask

  task automatic push_cmd(input logic ig, input logic dg, input logic cmd, input logic [AW-1:0] a);
    cmd_exp_t c;
    c.ig = ig; c.dg = dg; c.cmd = cmd; c.addr = a;
    cmd_q.push_back(c);
  endtask

  task automatic push_rd(input logic [1:0] v, input logic [DW-1:0] d);
    rd_exp_t r;
    r.vld = v; r.dat = d;
    rd_q.push_back(r);
  endtask

  // Monitor: compares every DUT output event against the queued expectations.
  initial begin : monitor
    int       wbeats;
    cmd_exp_t ce;
    rd_exp_t  re;
    wbeats = 0;
    forever begin
      @(negedge clk);
      if (br_cmd_en) begin
        if (cmd_q.size() == 0) fail_evt("cmd_unexpected");
        else begin
          ce = cmd_q.pop_front();
          chk("cmd_gnt", 64'({i_gnt, d_gnt}), 64'({ce.ig, ce.dg}));
          chk("cmd_rw", 64'(br_cmd), 64'(ce.cmd));
          chk("cmd_addr", 64'(br_addr), 64'(ce.addr));
          if (ce.cmd) wbeats = BC;
        end
      end else begin
        chk("gnt_without_cmd", 64'({i_gnt, d_gnt}), 64'd0);
      end
      if (wbeats > 0) begin
        if (wd_q.size() == 0) fail_evt("wbeat_unexpected");
        else begin
          chk("wr_data", br_wr_data, wd_q.pop_front());
          chk("wr_mask", 64'(br_data_mask), 64'(wm_q.pop_front()));
        end
        wbeats--;
      end else if (!br_cmd_en) begin
        chk("wr_data_zero", br_wr_data, 64'd0);
        chk("wr_mask_zero", 64'(br_data_mask), 64'd0);
      end
      if (i_rd_valid || d_rd_valid) begin
        if (rd_q.size() == 0) fail_evt("rd_unexpected");
        else begin
          re = rd_q.pop_front();
          chk("rd_port", 64'({i_rd_valid, d_rd_valid}), 64'(re.vld));
          chk("rd_data", rd_data, re.dat);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the grant pulse of one port, then drops that port's request.
  task automatic wait_gnt(input bit port_d, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(port_d ? d_gnt : i_gnt) && n < 20);
    if (!(port_d ? d_gnt : i_gnt)) fail_evt("gnt_wait_expired");
    else if (port_d) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  // Called in the ISSUE cycle of a read; returns BC beats with one gap after beat 1.
  task automatic serve_read(input bit port_d, input logic [DW-1:0] base);
    cyc();
    for (int k = 0; k < BC; k++) begin
      push_rd(port_d ? 2'b01 : 2'b10, base + 64'(k));
      br_rd_data       = base + 64'(k);
      br_rd_data_valid = 1'b1;
      cyc();
      if (k == 1) begin
        br_rd_data_valid = 1'b0;
        cyc();
      end
    end
    br_rd_data_valid = 1'b0;
  endtask

  initial begin : stim
    int n;
    rst = 1'b0;
    i_req = 0; d_req = 0; i_cmd = 0; d_cmd = 0;
    i_addr = '0; d_addr = '0;
    i_wr_data = '0; d_wr_data = '0; i_data_mask = '0; d_data_mask = '0;
    br_rd_data = '0; br_rd_data_valid = 0; br_busy = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_en", 64'(br_cmd_en), 64'd0);
    chk("rst_gnt", 64'({i_gnt, d_gnt}), 64'd0);
    chk("rst_cmd_addr", 64'({br_cmd, br_addr}), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_busy", 64'({i_busy, d_busy}), 64'd0);
    rst = 1'b1;
    cyc();

    // Tie from reset: I first, then D, then I (I re-requests while busy).
    push_cmd(1, 0, 0, 4'd1);
    push_cmd(0, 1, 0, 4'd2);
    push_cmd(1, 0, 0, 4'd3);
    i_req = 1; i_addr = 4'd1;
    d_req = 1; d_addr = 4'd2;
    wait_gnt(0, n);
    chk("tie_first_lat", 64'(n), 64'd1);
    i_req = 1; i_addr = 4'd3;
    serve_read(0, 64'h1000);
    wait_gnt(1, n);
    chk("tie_second_lat", 64'(n), 64'd1);
    serve_read(1, 64'h2000);
    wait_gnt(0, n);
    chk("tie_third_lat", 64'(n), 64'd1);
    serve_read(0, 64'h3000);

    // Single I read at address 5, then a stray beat while idle.
    push_cmd(1, 0, 0, 4'd5);
    i_req = 1; i_cmd = 0; i_addr = 4'd5;
    wait_gnt(0, n);
    chk("read_lat", 64'(n), 64'd1);
    serve_read(0, 64'h5000);
    @(negedge clk);
    chk("read_busy_released", 64'({i_busy, d_busy}), 64'd0);
    cyc();
    br_rd_data = 64'hBAD; br_rd_data_valid = 1'b1;
    cyc();
    br_rd_data_valid = 1'b0;

    // D write at address 3, beats 0xA..0xD; I drives distinct data to catch a wrong mux select.
    push_cmd(0, 1, 1, 4'd3);
    for (int k = 0; k < BC; k++) begin
      wd_q.push_back(64'hA + 64'(k));
      wm_q.push_back(8'hFF);
    end
    i_wr_data = 64'hDEAD; i_data_mask = 8'h00;
    d_req = 1; d_cmd = 1; d_addr = 4'd3; d_wr_data = 64'hA; d_data_mask = 8'hFF;
    wait_gnt(1, n);
    chk("wr_lat", 64'(n), 64'd1);
    for (int k = 1; k < BC; k++) begin
      cyc();
      d_wr_data = 64'hA + 64'(k);
      @(negedge clk);
      chk("wr_busy_held", 64'(d_busy), 64'd1);
    end
    cyc();
    @(negedge clk);
    chk("wr_busy_released", 64'(d_busy), 64'd0);
    d_cmd = 0;

    // br_busy stall: no command for 10 cycles, grant one cycle after release.
    br_busy = 1; i_req = 1; i_cmd = 0; i_addr = 4'd7;
    repeat (10) cyc();
    @(negedge clk);
    chk("stall_no_gnt", 64'(i_gnt), 64'd0);
    chk("stall_req_pending_busy", 64'(i_busy), 64'd1);
    cyc();
    push_cmd(1, 0, 0, 4'd7);
    br_busy = 0;
    wait_gnt(0, n);
    chk("stall_release_lat", 64'(n), 64'd1);
    serve_read(0, 64'h7000);

    // Reset after 2 of 4 read beats: remaining beats must be dropped.
    push_cmd(1, 0, 0, 4'd9);
    i_req = 1; i_addr = 4'd9;
    wait_gnt(0, n);
    cyc();
    for (int k = 0; k < 2; k++) begin
      push_rd(2'b10, 64'h9000 + 64'(k));
      br_rd_data = 64'h9000 + 64'(k); br_rd_data_valid = 1'b1;
      cyc();
    end
    br_rd_data = 64'h9002; br_rd_data_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk("midrst_rd_valid", 64'({i_rd_valid, d_rd_valid}), 64'd0);
    chk("midrst_busy", 64'({i_busy, d_busy}), 64'd0);
    chk("midrst_addr", 64'(br_addr), 64'd0);
    cyc();
    br_rd_data = 64'h9003;
    cyc();
    rst = 1'b1;
    cyc();
    br_rd_data_valid = 1'b0;
    push_cmd(1, 0, 0, 4'd4);
    i_req = 1; i_addr = 4'd4;
    wait_gnt(0, n);
    chk("post_rst_lat", 64'(n), 64'd1);
    serve_read(0, 64'h4000);

    repeat (3) cyc();
    chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("wd_q_drained", 64'(wd_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
